uart_rx_esp8266: RTL



---
 rtl/uart_rx_esp8266.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx_esp8266.sv
// 8N1 UART receiver for the ESP8266 TX line: 16x oversampling, 2-FF sync,
// majority-vote sampling, one-byte holding register with valid/ack handshake.
module uart_rx_esp8266 #(
  parameter int CLOCK      = 50000000,
  parameter int BAUDRATE   = 9600,
  parameter int BAUDCLOCK  = 16,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  rx_ack,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  frame_err,
  output logic                  overrun_err,
  output logic                  rx_busy,
  output logic                  BCLK
);

  // state   | meaning
  // S_IDLE  | line idle, waiting for a low sample on a tick
  // S_START | validating start bit (majority at tick 9)
  // S_DATA  | shifting in DATA_WIDTH bits, LSB first
  // S_STOP  | checking stop bit; early exit at tick 9
  // S_BREAK | stop bit was low, wait for line to return high
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  localparam int DIV_RAW = CLOCK / (BAUDRATE * BAUDCLOCK);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW      = $clog2(BAUDCLOCK);
  localparam int BW      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DW-1:0]         r_div_cnt;
  logic                  w_tick;
  logic                  r_sync1;
  logic                  r_sync2;
  logic [TW-1:0]         r_tick_cnt;
  logic [TW-1:0]         w_tick_nxt;
  logic [BW-1:0]         r_bit_cnt;
  logic                  r_s7;
  logic                  r_s8;
  logic                  w_maj;
  logic                  w_active;
  logic                  w_decide;
  logic                  w_start_det;
  logic                  w_busy;
  logic                  w_deliver;
  logic                  w_frame_bad;
  logic                  w_shift;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_frame_err;
  logic                  r_overrun;

  assign w_tick = (r_div_cnt == DW'(DIV - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_div_cnt <= '0;
    end else if (w_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + DW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= RX_IN;
      r_sync2 <= r_sync1;
    end
  end

  // r_tick_cnt holds the index of the previous tick; w_tick_nxt is the current one
  assign w_tick_nxt  = (r_tick_cnt == TW'(BAUDCLOCK - 1)) ? '0 : r_tick_cnt + TW'(1);
  assign w_active    = (r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP);
  assign w_decide    = w_tick && w_active && (w_tick_nxt == TW'(9));
  assign w_start_det = (r_state == S_IDLE) && w_tick && !r_sync2;
  assign w_maj       = (r_s7 & r_s8) | (r_s7 & r_sync2) | (r_s8 & r_sync2);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start_det) w_state_nxt = S_START;
      S_START: if (w_decide) w_state_nxt = w_maj ? S_IDLE : S_DATA;
      S_DATA:  if (w_decide && (r_bit_cnt == BW'(DATA_WIDTH - 1))) w_state_nxt = S_STOP;
      S_STOP:  if (w_decide) w_state_nxt = w_maj ? S_IDLE : S_BREAK;
      S_BREAK: if (w_tick && r_sync2) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy      = (r_state != S_IDLE);
    w_shift     = (r_state == S_DATA) && w_decide;
    w_deliver   = (r_state == S_STOP) && w_decide && w_maj;
    w_frame_bad = (r_state == S_STOP) && w_decide && !w_maj;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_s7       <= 1'b1;
      r_s8       <= 1'b1;
      r_shift    <= '0;
    end else begin
      if (w_start_det) begin
        r_tick_cnt <= '0;
        r_bit_cnt  <= '0;
      end else if (w_tick && w_active) begin
        r_tick_cnt <= w_tick_nxt;
        if (w_tick_nxt == TW'(7)) r_s7 <= r_sync2;
        if (w_tick_nxt == TW'(8)) r_s8 <= r_sync2;
      end
      if (w_shift) begin
        r_shift   <= {w_maj, r_shift[DATA_WIDTH-1:1]};
        r_bit_cnt <= r_bit_cnt + BW'(1);
      end
    end
  end

  // A same-cycle ack frees the holding register for the incoming byte
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_frame_bad;
      if (w_deliver) begin
        if (!r_valid || rx_ack) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
          if (rx_ack) r_overrun <= 1'b0;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (rx_ack) begin
        r_valid   <= 1'b0;
        r_overrun <= 1'b0;
      end
    end
  end

  assign rx_data     = r_data;
  assign rx_valid    = r_valid;
  assign frame_err   = r_frame_err;
  assign overrun_err = r_overrun;
  assign rx_busy     = w_busy;
  assign BCLK        = w_tick;

endmodule
